access_lcd_writer: RTL and testbench

Drives a standard HD44780-compatible 16x2 character LCD in 8-bit write-only mode. It shows the access controller's current status as a 16-character message on line 1. It sits directly downstream of the access-control top level and consumes its `greenLed`, `idLed` and `pwdLed` status outputs. After power-up it runs the LCD init sequence itself, then rewrites line 1 whenever the selected message changes.

---
 rtl/access_lcd_writer.sv | 255 +++++++++++++++++++++++++
 tb/tb_access_lcd_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_lcd_writer.sv
// access_lcd_writer
// Drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.
// After reset it waits INIT_WAIT cycles and then sends the init commands
// 0x38, 0x0C, 0x06 and 0x01. After that it rewrites line 1 with the status
// message chosen by greenLed > pwdLed > idLed > none whenever that choice
// differs from the message already on the display.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   greenLed   access granted            (selects code 4)
//   pwdLed     password accepted         (selects code 3)
//   idLed      user ID accepted          (selects code 2; none -> code 1)
//   lcd_data   LCD DB7..DB0
//   lcd_rs     0 = command, 1 = character data
//   lcd_rw     tied 0
//   lcd_e      LCD enable strobe
//   busy       high during init and during any line-1 rewrite
//   msg_shown  code of the message on the display (0 = none/init, 1..4).
//              It is 3 bits wide so that it can hold code 4.
module access_lcd_writer #(
    parameter int INIT_WAIT = 750000,
    parameter int E_PULSE   = 25,
    parameter int CMD_WAIT  = 2500,
    parameter int CLR_WAIT  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       greenLed,
    input  logic       pwdLed,
    input  logic       idLed,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       busy,
    output logic [2:0] msg_shown
);

    localparam int MAX_AB   = (INIT_WAIT > E_PULSE) ? INIT_WAIT : E_PULSE;
    localparam int MAX_CD   = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int MAX_WAIT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 1);

    localparam logic [127:0] MSG_USER_ID  = "ENTER USER ID   ";
    localparam logic [127:0] MSG_PASSWORD = "ENTER PASSWORD  ";
    localparam logic [127:0] MSG_PWD_OK   = "PASSWORD OK     ";
    localparam logic [127:0] MSG_GRANTED  = "ACCESS GRANTED  ";

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_t;

    state_t           state_reg, state_next;
    phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       idx_reg, idx_next;
    logic [2:0]       pending_reg, pending_next;
    logic [7:0]       data_reg, data_next;
    logic             rs_reg, rs_next;
    logic             e_reg, e_next;
    logic             busy_reg, busy_next;
    logic [2:0]       shown_reg, shown_next;

    logic [2:0]       sel_code;
    logic [3:0]       idx_inc;
    logic [CNT_W-1:0] wait_last;
    logic             byte_done;

    // Character table, row = message code, column = character index.
    // Row 0 is blank and is never actually written.
    logic [7:0] msg_rom [0:4][0:15];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            assign msg_rom[0][gi] = 8'h20;
            assign msg_rom[1][gi] = MSG_USER_ID [8*(15-gi) +: 8];
            assign msg_rom[2][gi] = MSG_PASSWORD[8*(15-gi) +: 8];
            assign msg_rom[3][gi] = MSG_PWD_OK  [8*(15-gi) +: 8];
            assign msg_rom[4][gi] = MSG_GRANTED [8*(15-gi) +: 8];
        end
    endgenerate

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign sel_code = greenLed ? 3'd4 :
                      pwdLed   ? 3'd3 :
                      idLed    ? 3'd2 : 3'd1;

    assign idx_inc = idx_reg + 4'd1;

    // Clear display needs the long settle time. It is the only command
    // that carries 0x01 with rs low.
    assign wait_last = (!rs_reg && data_reg == 8'h01) ? CLR_LAST : CMD_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_POWER_WAIT;
            phase_reg   <= PH_SETUP;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pending_reg <= '0;
            data_reg    <= '0;
            rs_reg      <= 1'b0;
            e_reg       <= 1'b0;
            busy_reg    <= 1'b1;
            shown_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
            data_reg    <= data_next;
            rs_reg      <= rs_next;
            e_reg       <= e_next;
            busy_reg    <= busy_next;
            shown_reg   <= shown_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        data_next    = data_reg;
        rs_next      = rs_reg;
        e_next       = e_reg;
        busy_next    = busy_reg;
        shown_next   = shown_reg;
        byte_done    = 1'b0;

        case (state_reg)
            ST_POWER_WAIT: begin
                if (cnt_reg == INIT_LAST) begin
                    state_next = ST_INIT;
                    phase_next = PH_SETUP;
                    cnt_next   = '0;
                    idx_next   = '0;
                    data_next  = init_cmd(2'd0);
                    rs_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // Status inputs are only looked at here, so a message that
                // is already being written always finishes intact.
                if (sel_code != shown_reg) begin
                    pending_next = sel_code;
                    busy_next    = 1'b1;
                    state_next   = ST_ADDR;
                    phase_next   = PH_SETUP;
                    cnt_next     = '0;
                    data_next    = 8'h80;
                    rs_next      = 1'b0;
                end
            end
            default: begin
                // Byte-write engine shared by INIT, ADDR and CHARS. Data and
                // rs change only on entry to SETUP, so they are stable for
                // the whole time the strobe is high.
                case (phase_reg)
                    PH_SETUP: begin
                        e_next     = 1'b1;
                        phase_next = PH_PULSE;
                        cnt_next   = '0;
                    end
                    PH_PULSE: begin
                        if (cnt_reg == PULSE_LAST) begin
                            e_next     = 1'b0;
                            phase_next = PH_WAIT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt_reg == wait_last) begin
                            byte_done = 1'b1;
                            cnt_next  = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                endcase

                if (byte_done) begin
                    phase_next = PH_SETUP;
                    case (state_reg)
                        ST_INIT: begin
                            if (idx_reg == 4'd3) begin
                                state_next = ST_IDLE;
                                busy_next  = 1'b0;
                                idx_next   = '0;
                            end else begin
                                idx_next  = idx_inc;
                                data_next = init_cmd(idx_inc[1:0]);
                            end
                        end
                        ST_ADDR: begin
                            state_next = ST_CHARS;
                            idx_next   = '0;
                            data_next  = msg_rom[pending_reg][0];
                            rs_next    = 1'b1;
                        end
                        default: begin
                            if (idx_reg == 4'd15) begin
                                state_next = ST_IDLE;
                                shown_next = pending_reg;
                                busy_next  = 1'b0;
                            end else begin
                                idx_next  = idx_inc;
                                data_next = msg_rom[pending_reg][idx_inc];
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    assign lcd_data  = data_reg;
    assign lcd_rs    = rs_reg;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_reg;
    assign busy      = busy_reg;
    assign msg_shown = shown_reg;

endmodule

// File: tb/tb_access_lcd_writer.sv
// Bench for access_lcd_writer with small timing parameters.
// A negedge monitor captures every lcd_e pulse. It also checks the strobe
// width and checks that data and rs stay fixed while the strobe is high.
// Expected byte streams come from a message-text model.
module tb_access_lcd_writer;

    localparam int INIT_WAIT = 10;
    localparam int E_PULSE   = 2;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 8;
    localparam int BYTE_P    = 1 + E_PULSE + CMD_WAIT;
    localparam int CLR_P     = 1 + E_PULSE + CLR_WAIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       greenLed, pwdLed, idLed;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [2:0] msg_shown;

    access_lcd_writer #(
        .INIT_WAIT(INIT_WAIT),
        .E_PULSE  (E_PULSE),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .greenLed (greenLed),
        .pwdLed   (pwdLed),
        .idLed    (idLed),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .busy     (busy),
        .msg_shown(msg_shown)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic string msg_text(input int code);
        case (code)
            1:       return "ENTER USER ID   ";
            2:       return "ENTER PASSWORD  ";
            3:       return "PASSWORD OK     ";
            4:       return "ACCESS GRANTED  ";
            default: return "                ";
        endcase
    endfunction

    function automatic int sel_code(input logic g, input logic p, input logic i);
        if (g) return 4;
        if (p) return 3;
        if (i) return 2;
        return 1;
    endfunction

    logic [8:0] exp_q[$];
    int model_shown = 0;

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_rewrite(input int code);
        string s;
        s = msg_text(code);
        exp_q.push_back({1'b0, 8'h80});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, s.getc(k)});
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } pulse_t;

    pulse_t pulses[$];
    int busy_rises[$];
    int busy_falls[$];
    logic in_pulse = 1'b0, busy_prev = 1'b0, changed = 1'b0;
    logic [8:0] hold_byte = '0;
    int width = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else if (lcd_e && !in_pulse) begin
            in_pulse  = 1'b1;
            width     = 1;
            changed   = 1'b0;
            hold_byte = {lcd_rs, lcd_data};
            pulses.push_back('{rs: lcd_rs, data: lcd_data, cyc: cyc});
        end else if (lcd_e) begin
            width++;
            if ({lcd_rs, lcd_data} != hold_byte) changed = 1'b1;
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            chk("e_width", width, E_PULSE);
            chk("e_hold", {31'd0, changed}, 0);
        end
        if (busy && !busy_prev) busy_rises.push_back(cyc);
        if (!busy && busy_prev) busy_falls.push_back(cyc);
        busy_prev = busy;
    end

    task automatic clear_capture();
        pulses.delete();
        busy_rises.delete();
        busy_falls.delete();
        exp_q.delete();
    endtask

    task automatic compare_pulses(input string name);
        int n;
        chk($sformatf("%s_count", name), pulses.size(), exp_q.size());
        n = (pulses.size() < exp_q.size()) ? pulses.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_byte%0d", name, k), {pulses[k].rs, pulses[k].data}, exp_q[k]);
    endtask

    // Apply inputs from idle and let any resulting rewrite finish.
    task automatic run_txn(input string name, input logic g, input logic p,
                           input logic i, input int exp_code);
        int rw, len, lat;
        clear_capture();
        rw = (exp_code != model_shown);
        if (rw) push_rewrite(exp_code);
        @(negedge clk);
        greenLed = g; pwdLed = p; idLed = i;
        repeat (20 * BYTE_P) @(negedge clk);
        compare_pulses(name);
        chk({name, "_shown"}, msg_shown, exp_code);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_busy_falls"}, busy_falls.size(), rw);
        if (rw) begin
            len = (busy_falls.size() > 0 && busy_rises.size() > 0) ? busy_falls[0] - busy_rises[0] : -1;
            lat = (pulses.size() > 0 && busy_rises.size() > 0) ? pulses[0].cyc - busy_rises[0] : -1;
            chk({name, "_busy_len"}, len, 17 * BYTE_P);
            chk({name, "_addr_latency"}, lat, 1);
        end
        $display("txn %s g=%0b p=%0b i=%0b exp_code=%0d shown=%0d pulses=%0d",
                 name, g, p, i, exp_code, msg_shown, pulses.size());
        model_shown = exp_code;
    endtask

    // Called right after reset release: check the init stream and the first rewrite.
    task automatic run_init(input string name, input int rel, input int exp_code);
        int first_rise, idle_entry, lat, len;
        push_init();
        push_rewrite(exp_code);
        repeat (INIT_WAIT + 3 * BYTE_P + CLR_P + 20 * BYTE_P) @(negedge clk);
        compare_pulses(name);
        first_rise = (pulses.size() > 0) ? pulses[0].cyc - rel : -1;
        chk({name, "_first_rise"}, first_rise, INIT_WAIT + 1);
        chk({name, "_busy_falls"}, busy_falls.size(), 2);
        idle_entry = (busy_falls.size() > 0) ? busy_falls[0] - rel : -1;
        chk({name, "_idle_entry"}, idle_entry, INIT_WAIT + 3 * BYTE_P + CLR_P);
        lat = (pulses.size() > 4 && busy_falls.size() > 0) ? pulses[4].cyc - busy_falls[0] : -1;
        chk({name, "_addr_latency"}, lat, 2);
        len = (busy_falls.size() > 1 && busy_rises.size() > 0) ? busy_falls[1] - busy_rises[0] : -1;
        chk({name, "_busy_len"}, len, 17 * BYTE_P);
        chk({name, "_shown"}, msg_shown, exp_code);
        chk({name, "_busy"}, busy, 0);
        $display("txn %s init+rewrite exp_code=%0d shown=%0d pulses=%0d",
                 name, exp_code, msg_shown, pulses.size());
        model_shown = exp_code;
    endtask

    typedef struct {
        logic g;
        logic p;
        logic i;
        int   exp_code;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rel, found, code;
        logic g, p, i;

        tbl[0] = '{g: 1'b0, p: 1'b0, i: 1'b1, exp_code: 2};
        tbl[1] = '{g: 1'b0, p: 1'b1, i: 1'b1, exp_code: 3};
        tbl[2] = '{g: 1'b1, p: 1'b1, i: 1'b1, exp_code: 4};
        tbl[3] = '{g: 1'b0, p: 1'b1, i: 1'b0, exp_code: 3};
        tbl[4] = '{g: 1'b1, p: 1'b0, i: 1'b0, exp_code: 4};
        tbl[5] = '{g: 1'b1, p: 1'b0, i: 1'b1, exp_code: 4};
        tbl[6] = '{g: 1'b0, p: 1'b0, i: 1'b0, exp_code: 1};

        greenLed = 0; pwdLed = 0; idLed = 0;
        rst = 0;
        #3 rst = 1;
        #1;
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_shown", msg_shown, 0);
        $display("txn reset e=%0b data=0x%0h busy=%0b shown=%0d", lcd_e, lcd_data, busy, msg_shown);

        repeat (2) @(negedge clk);
        clear_capture();
        rst = 0;
        rel = cyc;
        run_init("init", rel, 1);

        for (int k = 0; k < 7; k++)
            run_txn($sformatf("tbl%0d", k), tbl[k].g, tbl[k].p, tbl[k].i, tbl[k].exp_code);

        // A change 20 cycles into a code-2 rewrite is shown only after that rewrite ends.
        clear_capture();
        push_rewrite(2);
        push_rewrite(3);
        @(negedge clk);
        idLed = 1;
        repeat (20) @(negedge clk);
        pwdLed = 1;
        repeat (40 * BYTE_P) @(negedge clk);
        compare_pulses("late_pwd");
        chk("late_pwd_shown", msg_shown, 3);
        $display("txn late_pwd shown=%0d pulses=%0d", msg_shown, pulses.size());
        model_shown = 3;

        // A short idLed pulse inside a rewrite to code 1 causes no extra rewrite.
        clear_capture();
        push_rewrite(1);
        @(negedge clk);
        idLed = 0; pwdLed = 0;
        repeat (10) @(negedge clk);
        idLed = 1;
        repeat (5) @(negedge clk);
        idLed = 0;
        repeat (40 * BYTE_P) @(negedge clk);
        compare_pulses("blip");
        chk("blip_shown", msg_shown, 1);
        $display("txn blip shown=%0d pulses=%0d", msg_shown, pulses.size());
        model_shown = 1;

        for (int k = 0; k < 10; k++) begin
            g = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            i = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", k), g, p, i, sel_code(g, p, i));
        end

        // Reset while the strobe is high in the middle of the characters.
        clear_capture();
        @(negedge clk);
        if (model_shown == 1) begin
            greenLed = 0; pwdLed = 0; idLed = 1;
        end else begin
            greenLed = 0; pwdLed = 0; idLed = 0;
        end
        code = sel_code(greenLed, pwdLed, idLed);
        found = 0;
        for (int k = 0; k < 40 * BYTE_P; k++) begin
            @(negedge clk);
            if (lcd_e && pulses.size() >= 4) begin
                found = 1;
                break;
            end
        end
        chk("midchars_found", found, 1);
        #2 rst = 1;
        #1;
        chk("midrst_e", lcd_e, 0);
        chk("midrst_data", lcd_data, 0);
        chk("midrst_rs", lcd_rs, 0);
        chk("midrst_shown", msg_shown, 0);
        chk("midrst_busy", busy, 1);
        $display("txn midrst e=%0b data=0x%0h busy=%0b shown=%0d", lcd_e, lcd_data, busy, msg_shown);
        repeat (3) @(negedge clk);
        clear_capture();
        rst = 0;
        rel = cyc;
        run_init("reinit", rel, code);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
